// File: rtl/round_ctrl_if.sv
// Bundles the round controller's button, game-state and scorer-facing signals.
// The controller uses the slave view; whatever drives the buttons uses the master view.
interface round_ctrl_if;
    logic i_pbl;
    logic i_pbr;
    logic i_gameOver;
    logic o_ledsOn;
    logic o_winRnd;
    logic o_right;

    modport master (
        output i_pbl,
        output i_pbr,
        output i_gameOver,
        input  o_ledsOn,
        input  o_winRnd,
        input  o_right
    );

    modport slave (
        input  i_pbl,
        input  i_pbr,
        input  i_gameOver,
        output o_ledsOn,
        output o_winRnd,
        output o_right
    );
endinterface

// File: rtl/round_ctrl.sv
// Round controller for the tug-of-war game.
// It synchronises both pushbuttons and runs the dark/lit light cycle with a
// pseudo-random dark time. It decides who pushed first and reports that to the
// scorer as a one-cycle winrnd pulse with registered right/leds_on qualifiers.
// Once the scorer shows a win it freezes until the next reset.
// Every counter load is the wanted phase length minus one, so a phase of N
// cycles ends on the N-th clock edge after it starts.
module round_ctrl #(
    parameter int MIN_DELAY   = 50_000_000,
    parameter int RAND_BITS   = 24,
    parameter int LIT_TIMEOUT = 100_000_000,
    parameter int HOLD_CYCLES = 10_000_000,
    parameter int CNT_W       = 28
) (
    input  logic        i_clk,
    input  logic        i_rst,
    round_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DARK = 3'd1,
        LIT  = 3'd2,
        HOLD = 3'd3,
        STOP = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_lfsr;
    logic             r_tiePri;
    logic             r_ledsOn;
    logic             r_winRnd;
    logic             r_right;

    logic r_pblS1, r_pblS2, r_pblS3;
    logic r_pbrS1, r_pbrS2, r_pbrS3;

    logic             w_edgeL;
    logic             w_edgeR;
    logic             w_anyEdge;
    logic             w_bothEdge;
    logic             w_bothIdle;
    logic             w_pushRight;
    logic             w_cntZero;
    logic             w_lfsrFb;
    logic [CNT_W-1:0] w_rand;
    logic [CNT_W-1:0] w_darkLoad;
    logic [CNT_W-1:0] w_litLoad;
    logic [CNT_W-1:0] w_holdLoad;

    // Two synchroniser flops per button, then a history flop for rising-edge detection.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_pblS1 <= 1'b0;
            r_pblS2 <= 1'b0;
            r_pblS3 <= 1'b0;
            r_pbrS1 <= 1'b0;
            r_pbrS2 <= 1'b0;
            r_pbrS3 <= 1'b0;
        end else begin
            r_pblS1 <= bus.i_pbl;
            r_pblS2 <= r_pblS1;
            r_pblS3 <= r_pblS2;
            r_pbrS1 <= bus.i_pbr;
            r_pbrS2 <= r_pbrS1;
            r_pbrS3 <= r_pbrS2;
        end
    end

    // Free-running Fibonacci LFSR (x^16+x^14+x^13+x^11+1); the non-zero seed keeps it out of the lock-up state.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsrFb};
        end
    end

    assign w_lfsrFb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Random part of the dark time; wider requests than the LFSR see zeros in the upper bits.
    generate
        if (RAND_BITS <= 16) begin : g_randNarrow
            assign w_rand = CNT_W'(r_lfsr[RAND_BITS-1:0]);
        end else begin : g_randWide
            assign w_rand = CNT_W'(r_lfsr);
        end
    endgenerate

    assign w_darkLoad  = CNT_W'(MIN_DELAY - 1) + w_rand;
    assign w_litLoad   = CNT_W'(LIT_TIMEOUT - 1);
    assign w_holdLoad  = CNT_W'(HOLD_CYCLES - 1);
    assign w_cntZero   = (r_cnt == '0);

    assign w_edgeL     = r_pblS2 & ~r_pblS3;
    assign w_edgeR     = r_pbrS2 & ~r_pbrS3;
    assign w_anyEdge   = w_edgeL | w_edgeR;
    assign w_bothEdge  = w_edgeL & w_edgeR;
    assign w_bothIdle  = ~r_pblS2 & ~r_pbrS2;
    assign w_pushRight = w_bothEdge ? r_tiePri : w_edgeR;

    // Round state machine; game_over beats any push, and every output is registered here.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_tiePri <= 1'b0;
            r_ledsOn <= 1'b0;
            r_winRnd <= 1'b0;
            r_right  <= 1'b0;
        end else if (bus.i_gameOver) begin
            r_state  <= STOP;
            r_ledsOn <= 1'b0;
            r_winRnd <= 1'b0;
        end else begin
            r_winRnd <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ledsOn <= 1'b0;
                    if (w_bothIdle) begin
                        r_cnt   <= w_darkLoad;
                        r_state <= DARK;
                    end
                end
                DARK: begin
                    r_ledsOn <= 1'b0;
                    if (w_anyEdge) begin
                        r_winRnd <= 1'b1;
                        r_right  <= w_pushRight;
                        if (w_bothEdge) begin
                            r_tiePri <= ~r_tiePri;
                        end
                        r_cnt   <= w_holdLoad;
                        r_state <= HOLD;
                    end else if (w_cntZero) begin
                        r_ledsOn <= 1'b1;
                        r_cnt    <= w_litLoad;
                        r_state  <= LIT;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                LIT: begin
                    if (w_anyEdge) begin
                        r_ledsOn <= 1'b1;
                        r_winRnd <= 1'b1;
                        r_right  <= w_pushRight;
                        if (w_bothEdge) begin
                            r_tiePri <= ~r_tiePri;
                        end
                        r_cnt   <= w_holdLoad;
                        r_state <= HOLD;
                    end else if (w_cntZero) begin
                        r_ledsOn <= 1'b0;
                        r_cnt    <= w_darkLoad;
                        r_state  <= DARK;
                    end else begin
                        r_ledsOn <= 1'b1;
                        r_cnt    <= r_cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    r_ledsOn <= 1'b0;
                    if (!w_cntZero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (w_bothIdle) begin
                        r_cnt   <= w_darkLoad;
                        r_state <= DARK;
                    end
                end
                STOP: begin
                    r_ledsOn <= 1'b0;
                end
                default: begin
                    r_ledsOn <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_ledsOn = r_ledsOn;
    assign bus.o_winRnd = r_winRnd;
    assign bus.o_right  = r_right;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed testbench for round_ctrl with short simulation timings
// (MIN_DELAY=20, RAND_BITS=3, LIT_TIMEOUT=30, HOLD_CYCLES=8).
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_round_ctrl;

    logic clk;
    logic rst;
    int   checks    = 0;
    int   failures  = 0;
    int   winCount  = 0;

    round_ctrl_if bus ();

    round_ctrl #(
        .MIN_DELAY  (20),
        .RAND_BITS  (3),
        .LIT_TIMEOUT(30),
        .HOLD_CYCLES(8),
        .CNT_W      (28)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally every winrnd pulse so tests can spot extra or missing pulses.
    always @(negedge clk) begin
        if (bus.o_winRnd === 1'b1) winCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the lights are lit, giving up after 100 cycles.
    task automatic wait_lit();
        int n = 0;
        while (bus.o_ledsOn !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.i_pbl = 1'b0;
        bus.i_pbr = 1'b0;
        bus.i_gameOver = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.o_ledsOn !== 1'b0) begin failures++; $display("[TB] FAIL reset_leds: got %b want 0", bus.o_ledsOn); end
        checks++;
        if (bus.o_winRnd !== 1'b0) begin failures++; $display("[TB] FAIL reset_winrnd: got %b want 0", bus.o_winRnd); end
        checks++;
        if (bus.o_right !== 1'b0) begin failures++; $display("[TB] FAIL reset_right: got %b want 0", bus.o_right); end
        checks++;
        if (dut.r_lfsr !== 16'hACE1) begin failures++; $display("[TB] FAIL reset_lfsr: got %h want ace1", dut.r_lfsr); end
    endtask

    task automatic test_idle_cycle();
        int n = 0;
        int m = 0;
        int w0;
        w0 = winCount;
        rst = 1'b1;
        while (bus.o_ledsOn !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (bus.o_ledsOn !== 1'b1 || (n - 1) < 20 || (n - 1) > 27) begin
            failures++;
            $display("[TB] FAIL idle_dark_time: leds=%b after %0d cycles, want lit after 20..27", bus.o_ledsOn, n - 1);
        end
        while (bus.o_ledsOn === 1'b1 && m < 60) begin
            tick();
            m++;
        end
        checks++;
        if (m != 30) begin failures++; $display("[TB] FAIL idle_lit_time: lit for %0d cycles want 30", m); end
        checks++;
        if (winCount != w0) begin failures++; $display("[TB] FAIL idle_no_winrnd: pulses %0d want 0", winCount - w0); end
    endtask

    task automatic test_lit_push_right();
        int w0;
        wait_lit();
        checks++;
        if (bus.o_ledsOn !== 1'b1) begin failures++; $display("[TB] FAIL lit_wait: leds %b want 1", bus.o_ledsOn); end
        w0 = winCount;
        bus.i_pbr = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.o_winRnd !== 1'b0) begin failures++; $display("[TB] FAIL lit_push_early: winrnd %b want 0", bus.o_winRnd); end
        tick();
        checks++;
        if (bus.o_winRnd !== 1'b1 || bus.o_right !== 1'b1 || bus.o_ledsOn !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lit_push: winrnd/right/leds %b%b%b want 111", bus.o_winRnd, bus.o_right, bus.o_ledsOn);
        end
        tick();
        checks++;
        if (bus.o_winRnd !== 1'b0 || bus.o_ledsOn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lit_push_after: winrnd/leds %b%b want 00", bus.o_winRnd, bus.o_ledsOn);
        end
        bus.i_pbr = 1'b0;
        tick();
        checks++;
        if (winCount != w0 + 1) begin failures++; $display("[TB] FAIL lit_push_count: pulses %0d want 1", winCount - w0); end
    endtask

    task automatic test_dark_push_left();
        int w0;
        int n = 0;
        repeat (9) tick();
        checks++;
        if (bus.o_ledsOn !== 1'b0) begin failures++; $display("[TB] FAIL dark_before_push: leds %b want 0", bus.o_ledsOn); end
        w0 = winCount;
        bus.i_pbl = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (bus.o_winRnd !== 1'b1 || bus.o_right !== 1'b0 || bus.o_ledsOn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dark_push: winrnd/right/leds %b%b%b want 100", bus.o_winRnd, bus.o_right, bus.o_ledsOn);
        end
        repeat (20) tick();
        bus.i_pbl = 1'b0;
        while (bus.o_ledsOn !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n < 23 || n > 30) begin
            failures++;
            $display("[TB] FAIL hold_until_release: lit %0d cycles after release want 23..30", n);
        end
        checks++;
        if (winCount != w0 + 1) begin failures++; $display("[TB] FAIL dark_push_count: pulses %0d want 1", winCount - w0); end
    endtask

    task automatic test_tie();
        for (int r = 0; r < 2; r++) begin
            logic expRight;
            expRight = (r == 1);
            wait_lit();
            bus.i_pbl = 1'b1;
            bus.i_pbr = 1'b1;
            tick();
            tick();
            tick();
            checks++;
            if (bus.o_winRnd !== 1'b1 || bus.o_right !== expRight) begin
                failures++;
                $display("[TB] FAIL tie_round%0d: winrnd/right %b%b want 1%b", r, bus.o_winRnd, bus.o_right, expRight);
            end
            tick();
            bus.i_pbl = 1'b0;
            bus.i_pbr = 1'b0;
            tick();
        end
    endtask

    task automatic test_game_over();
        int  w0;
        logic sawLeds;
        wait_lit();
        checks++;
        if (bus.o_ledsOn !== 1'b1) begin failures++; $display("[TB] FAIL over_wait: leds %b want 1", bus.o_ledsOn); end
        bus.i_pbl = 1'b1;
        tick();
        tick();
        bus.i_gameOver = 1'b1;
        tick();
        checks++;
        if (bus.o_winRnd !== 1'b0 || bus.o_ledsOn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL over_priority: winrnd/leds %b%b want 00", bus.o_winRnd, bus.o_ledsOn);
        end
        tick();
        w0 = winCount;
        repeat (2) tick();
        bus.i_gameOver = 1'b0;
        bus.i_pbl = 1'b0;
        repeat (2) tick();
        bus.i_pbr = 1'b1;
        sawLeds = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 5) bus.i_pbr = 1'b0;
            if (bus.o_ledsOn !== 1'b0) sawLeds = 1'b1;
        end
        checks++;
        if (sawLeds !== 1'b0 || winCount != w0) begin
            failures++;
            $display("[TB] FAIL stop_frozen: leds seen %b, pulses %0d want 0/0", sawLeds, winCount - w0);
        end
    endtask

    task automatic test_reset_in_hold();
        int w0;
        int n = 0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        wait_lit();
        bus.i_pbr = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (bus.o_winRnd !== 1'b1 || bus.o_right !== 1'b1) begin
            failures++;
            $display("[TB] FAIL restart_push: winrnd/right %b%b want 11", bus.o_winRnd, bus.o_right);
        end
        bus.i_pbr = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        w0 = winCount;
        checks++;
        if (bus.o_ledsOn !== 1'b0 || bus.o_winRnd !== 1'b0 || bus.o_right !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_reset_outputs: leds/winrnd/right %b%b%b want 000", bus.o_ledsOn, bus.o_winRnd, bus.o_right);
        end
        checks++;
        if (dut.r_lfsr !== 16'hACE1) begin failures++; $display("[TB] FAIL hold_reset_lfsr: got %h want ace1", dut.r_lfsr); end
        rst = 1'b1;
        while (bus.o_ledsOn !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if ((n - 1) < 20 || (n - 1) > 27) begin
            failures++;
            $display("[TB] FAIL hold_reset_restart: lit after %0d cycles want 20..27", n - 1);
        end
        checks++;
        if (winCount != w0) begin failures++; $display("[TB] FAIL hold_reset_no_winrnd: pulses %0d want 0", winCount - w0); end
    endtask

    initial begin
        test_reset();
        test_idle_cycle();
        test_lit_push_right();
        test_dark_push_left();
        test_tie();
        test_game_over();
        test_reset_in_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
